gcd_operand_driver: RTL and testbench

Initiator-side front end for the subtraction-based GCD controller/datapath pair.
- Accepts an operand pair on a valid/ready interface.
- Serialises the pair onto the core's shared 8-bit data input (A, then B), raises and holds start, and waits for done.
- Captures the core's result and returns it on a valid/ready result interface.
- Short-circuits zero operands, which would otherwise hang the core.
- Guards against a stuck core with a timeout.

---
 rtl/gcd_pkg.sv | 28 ++
 rtl/gcd_timeout_ctr.sv | 40 ++++
 rtl/gcd_operand_driver.sv | 146 ++++++++++++++
 tb/tb_gcd_operand_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD operand driver:
//   - default data width, timeout limit and timeout counter width
//   - driver state encoding (3-bit, same width as the GCD controller's state)
//   - a helper that says which states keep the core's start level asserted
// -----------------------------------------------------------------------------
package gcd_pkg;

  localparam int GCD_DATA_WIDTH     = 8;
  localparam int GCD_TIMEOUT_CYCLES = 1023;
  localparam int GCD_TO_W           = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } gcd_state_t;

  // The core runs while start is high; dropping it (RESP/IDLE) returns the
  // controller to its idle state before the next operation.
  function automatic logic drives_core(input gcd_state_t s);
    return (s == ST_LOAD_A) || (s == ST_LOAD_B) || (s == ST_WAIT);
  endfunction

endpackage : gcd_pkg

// File: rtl/gcd_timeout_ctr.sv
// -----------------------------------------------------------------------------
// gcd_timeout_ctr
// Up-counter with synchronous clear and enable. tc flags the cycle in which
// the TERMINAL-th enabled cycle after a clear is in progress, so the owner can
// act on the same edge that would complete that many cycles.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous, active-high reset (count -> 0)
//   clr    - synchronous clear (wins over en)
//   en     - count enable
//   tc     - count equals TERMINAL-1
// -----------------------------------------------------------------------------
module gcd_timeout_ctr #(
  parameter int W        = 10,
  parameter int TERMINAL = 1023
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule : gcd_timeout_ctr

// File: rtl/gcd_operand_driver.sv
// -----------------------------------------------------------------------------
// gcd_operand_driver
// Initiator front end for the subtraction-based GCD core. Takes an operand
// pair on a valid/ready interface, serialises A then B onto the core's shared
// data bus while holding start high, waits for done (bounded by a timeout),
// and returns the result on a valid/ready interface. Zero operands bypass the
// core, which would otherwise never finish.
// Ports:
//   i_clk, i_rst          - clock, synchronous active-high reset
//   in_valid/in_ready     - operand pair handshake; in_a, in_b operands
//   gcd_start, gcd_data   - start level and data bus to the core
//   gcd_done, gcd_result  - completion and result from the core
//   res_valid/res_ready   - result handshake; res_gcd result,
//                           res_err = 1 on timeout (res_gcd = 0 then)
// All outputs are registered.
// -----------------------------------------------------------------------------
module gcd_operand_driver
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH     = GCD_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES,
  parameter int TO_W           = GCD_TO_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  gcd_start,
  output logic [DATA_WIDTH-1:0] gcd_data,
  input  logic                  gcd_done,
  input  logic [DATA_WIDTH-1:0] gcd_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_gcd,
  output logic                  res_err
);

  gcd_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] gcd_data_d, res_gcd_d;
  logic                  res_err_d;
  logic                  ctr_clr, ctr_en, ctr_tc;

  gcd_timeout_ctr #(
    .W        (TO_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d    = state_q;
    b_d        = b_q;
    gcd_data_d = gcd_data;
    res_gcd_d  = res_gcd;
    res_err_d  = res_err;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          b_d = in_b;
          if (in_a == '0 || in_b == '0) begin
            // gcd(x,0) = x and gcd(0,0) is reported as 0: a|b covers both.
            state_d   = ST_RESP;
            res_gcd_d = in_a | in_b;
            res_err_d = 1'b0;
          end else begin
            // A goes straight onto the bus so it is present during LOAD_A.
            state_d    = ST_LOAD_A;
            gcd_data_d = in_a;
          end
        end
      end

      ST_LOAD_A: begin
        state_d    = ST_LOAD_B;
        gcd_data_d = b_q;
      end

      ST_LOAD_B: begin
        state_d = ST_WAIT;
        ctr_clr = 1'b1;
      end

      ST_WAIT: begin
        ctr_en = 1'b1;
        // done wins over a coincident timeout.
        if (gcd_done) begin
          state_d   = ST_RESP;
          res_gcd_d = gcd_result;
          res_err_d = 1'b0;
        end else if (ctr_tc) begin
          state_d   = ST_RESP;
          res_gcd_d = '0;
          res_err_d = 1'b1;
        end
      end

      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      in_ready  <= 1'b1;
      gcd_start <= 1'b0;
      gcd_data  <= '0;
      res_valid <= 1'b0;
      res_gcd   <= '0;
      res_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      in_ready  <= (state_d == ST_IDLE);
      gcd_start <= drives_core(state_d);
      gcd_data  <= gcd_data_d;
      res_valid <= (state_d == ST_RESP);
      res_gcd   <= res_gcd_d;
      res_err   <= res_err_d;
    end
  end

endmodule : gcd_operand_driver

// File: tb/tb_gcd_operand_driver.sv
// -----------------------------------------------------------------------------
// tb_gcd_operand_driver
// Directed bench for gcd_operand_driver with a behavioural GCD core model.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gcd_operand_driver;

  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b;
  logic          gcd_start;
  logic [DW-1:0] gcd_data;
  logic          gcd_done;
  logic [DW-1:0] gcd_result;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_gcd;
  logic          res_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic core_hold;   // when set, the core model never raises done

  always #5 i_clk = ~i_clk;

  gcd_operand_driver #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16),
    .TO_W           (10)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_gcd    (res_gcd),
    .res_err    (res_err)
  );

  // ---------------------------------------------------------------------------
  // Core model: grabs A on the first start cycle, B on the second, then raises
  // done with the GCD four cycles later and holds it until start drops.
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y;
    x = a;
    y = b;
    for (int i = 0; i < 512 && x != y; i++) begin
      if (x > y) x = x - y;
      else       y = y - x;
    end
    return x;
  endfunction

  logic [1:0]    core_ph;
  logic [2:0]    core_dly;
  logic [DW-1:0] core_a, core_b;

  always @(posedge i_clk) begin
    if (i_rst || !gcd_start) begin
      core_ph  <= 2'd0;
      core_dly <= 3'd0;
      gcd_done <= 1'b0;
    end else begin
      case (core_ph)
        2'd0: begin core_a <= gcd_data; core_ph <= 2'd1; end
        2'd1: begin core_b <= gcd_data; core_ph <= 2'd2; core_dly <= 3'd0; end
        2'd2: begin
          if (!core_hold) begin
            core_dly <= core_dly + 3'd1;
            if (core_dly == 3'd3) begin
              gcd_done   <= 1'b1;
              gcd_result <= ref_gcd(core_a, core_b);
              core_ph    <= 2'd3;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a pair, wait (bounded) for the accept edge, and return on the
  // falling edge just after it with in_valid optionally still asserted.
  task automatic apply_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit keep);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(negedge i_clk);
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid and check the result fields. For completed
  // operations also check that res_valid follows the first sampled done by
  // exactly one cycle.
  task automatic wait_result(input string tag, input logic [DW-1:0] exp_gcd, input logic exp_err);
    int n, done_at;
    n = 0;
    done_at = -1;
    while (!res_valid && n < 200) begin
      if (gcd_done && done_at < 0) done_at = n;
      @(negedge i_clk);
      n++;
    end
    check({tag, "_valid"}, res_valid, 1'b1);
    check({tag, "_gcd"},   res_gcd,   exp_gcd);
    check({tag, "_err"},   res_err,   exp_err);
    check({tag, "_start"}, gcd_start, 1'b0);
    if (!exp_err) check({tag, "_lat"}, n - done_at, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    i_rst     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b1;
    core_hold = 1'b0;
    gcd_result = '0;
    repeat (2) @(negedge i_clk);

    // Reset state
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_start",     gcd_start, 1'b0);
    check("rst_data",      gcd_data,  8'h00);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_gcd",   res_gcd,   8'h00);
    check("rst_res_err",   res_err,   1'b0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Basic pair: A then B on consecutive cycles, gcd(0x50,0x88) = 0x08
    apply_pair(8'h50, 8'h88, 1'b0);
    check("t1_load_a_start", gcd_start, 1'b1);
    check("t1_load_a_data",  gcd_data,  8'h50);
    check("t1_in_ready",     in_ready,  1'b0);
    @(negedge i_clk);
    check("t1_load_b_start", gcd_start, 1'b1);
    check("t1_load_b_data",  gcd_data,  8'h88);
    wait_result("t1", 8'h08, 1'b0);
    @(negedge i_clk);
    check("t1_done_valid", res_valid, 1'b0);
    check("t1_done_ready", in_ready,  1'b1);

    // Timeout: core never answers, 16 WAIT cycles then error
    core_hold = 1'b1;
    apply_pair(8'h50, 8'h88, 1'b0);
    @(negedge i_clk);                      // in LOAD_B
    repeat (16) @(negedge i_clk);          // 15 WAIT cycles elapsed
    check("to_early_valid", res_valid, 1'b0);
    check("to_early_start", gcd_start, 1'b1);
    check("to_wait_data",   gcd_data,  8'h88);
    @(negedge i_clk);
    check("to_valid", res_valid, 1'b1);
    check("to_err",   res_err,   1'b1);
    check("to_gcd",   res_gcd,   8'h00);
    check("to_start", gcd_start, 1'b0);
    core_hold = 1'b0;
    @(negedge i_clk);

    // Zero-operand bypass, result one cycle after accept, core untouched
    apply_pair(8'h00, 8'h2A, 1'b0);
    check("byp1_valid", res_valid, 1'b1);
    check("byp1_gcd",   res_gcd,   8'h2A);
    check("byp1_err",   res_err,   1'b0);
    check("byp1_start", gcd_start, 1'b0);
    @(negedge i_clk);
    check("byp1_idle_start", gcd_start, 1'b0);
    apply_pair(8'h00, 8'h00, 1'b0);
    check("byp2_valid", res_valid, 1'b1);
    check("byp2_gcd",   res_gcd,   8'h00);
    check("byp2_start", gcd_start, 1'b0);
    @(negedge i_clk);

    // Backpressure: result 0x0F held while res_ready=0, new pair ignored
    res_ready = 1'b0;
    apply_pair(8'h2D, 8'h1E, 1'b0);
    wait_result("bp", 8'h0F, 1'b0);
    in_valid = 1'b1;
    in_a     = 8'h31;
    in_b     = 8'h23;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("bp_hold_valid", res_valid, 1'b1);
      check("bp_hold_gcd",   res_gcd,   8'h0F);
      check("bp_hold_ready", in_ready,  1'b0);
    end
    res_ready = 1'b1;
    @(negedge i_clk);                      // handshake edge passed
    check("bp_release_valid", res_valid, 1'b0);
    check("bp_release_ready", in_ready,  1'b1);
    check("bp_not_accepted",  gcd_start, 1'b0);
    @(negedge i_clk);                      // accept edge passed
    in_valid = 1'b0;
    check("bp_next_start", gcd_start, 1'b1);
    check("bp_next_data",  gcd_data,  8'h31);
    wait_result("bp_next", 8'h07, 1'b0);
    @(negedge i_clk);

    // Reset during WAIT aborts at once, then a fresh pair still works
    core_hold = 1'b1;
    apply_pair(8'h50, 8'h88, 1'b0);
    repeat (5) @(negedge i_clk);
    check("rw_in_wait", gcd_start, 1'b1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rw_start", gcd_start, 1'b0);
    check("rw_valid", res_valid, 1'b0);
    check("rw_ready", in_ready,  1'b1);
    check("rw_gcd",   res_gcd,   8'h00);
    i_rst = 1'b0;
    core_hold = 1'b0;
    @(negedge i_clk);
    apply_pair(8'h24, 8'h18, 1'b0);
    wait_result("rw_next", 8'h0C, 1'b0);
    @(negedge i_clk);

    // Back-to-back with in_valid held: second pair only taken in IDLE
    apply_pair(8'h50, 8'h88, 1'b1);
    in_a = 8'h1B;
    in_b = 8'h12;
    check("b2b_busy_ready", in_ready, 1'b0);
    check("b2b_first_data", gcd_data, 8'h50);
    wait_result("b2b_1", 8'h08, 1'b0);
    @(negedge i_clk);
    check("b2b_idle_ready", in_ready,  1'b1);
    check("b2b_idle_start", gcd_start, 1'b0);
    @(negedge i_clk);
    in_valid = 1'b0;
    check("b2b_second_start", gcd_start, 1'b1);
    check("b2b_second_data",  gcd_data,  8'h1B);
    wait_result("b2b_2", 8'h09, 1'b0);
    @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_gcd_operand_driver
